// File: rtl/ibex_multdiv_arbiter_pkg.sv
// rtl/ibex_multdiv_arbiter_pkg.sv - shared types for the multdiv arbiter
// Operator encoding, arbiter FSM states and the latched request record.
package ibex_multdiv_arbiter_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  typedef struct packed {
    md_op_e      operator;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } md_req_t;

endpackage

// File: rtl/ibex_multdiv_arbiter_if.sv
// rtl/ibex_multdiv_arbiter_if.sv - requester, response and unit-side bundle
// slave is the arbiter's view; master is the requesters/unit view.
interface ibex_multdiv_arbiter_if;

  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [1:0]  req0_operator_i;
  logic [1:0]  req0_signed_mode_i;
  logic [31:0] req0_op_a_i;
  logic [31:0] req0_op_b_i;
  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [1:0]  req1_operator_i;
  logic [1:0]  req1_signed_mode_i;
  logic [31:0] req1_op_a_i;
  logic [31:0] req1_op_b_i;
  logic        kill0_i;
  logic        kill1_i;
  logic        rsp0_valid_o;
  logic        rsp0_ready_i;
  logic [31:0] rsp0_result_o;
  logic        rsp1_valid_o;
  logic        rsp1_ready_i;
  logic [31:0] rsp1_result_o;
  logic        md_mult_en_o;
  logic        md_div_en_o;
  logic [1:0]  md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_op_a_o;
  logic [31:0] md_op_b_o;
  logic [31:0] md_result_i;
  logic        md_valid_i;

  modport slave (
    input  req0_valid_i, req0_operator_i, req0_signed_mode_i, req0_op_a_i, req0_op_b_i,
    input  req1_valid_i, req1_operator_i, req1_signed_mode_i, req1_op_a_i, req1_op_b_i,
    input  kill0_i, kill1_i, rsp0_ready_i, rsp1_ready_i, md_result_i, md_valid_i,
    output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp0_result_o, rsp1_valid_o, rsp1_result_o,
    output md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o
  );

  modport master (
    output req0_valid_i, req0_operator_i, req0_signed_mode_i, req0_op_a_i, req0_op_b_i,
    output req1_valid_i, req1_operator_i, req1_signed_mode_i, req1_op_a_i, req1_op_b_i,
    output kill0_i, kill1_i, rsp0_ready_i, rsp1_ready_i, md_result_i, md_valid_i,
    input  req0_ready_o, req1_ready_o, rsp0_valid_o, rsp0_result_o, rsp1_valid_o, rsp1_result_o,
    input  md_mult_en_o, md_div_en_o, md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o
  );

endinterface

// File: rtl/ibex_multdiv_arbiter_rr_arb2.sv
// rtl/ibex_multdiv_arbiter_rr_arb2.sv - two-way one-hot grant picker
// Ties go to the requester that did not win last, or always to req 0 in fixed mode.
module ibex_rr_arb2 #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = (ROUND_ROBIN && !last_grant_i) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ibex_multdiv_arbiter.sv
// rtl/ibex_multdiv_arbiter.sv - shares one slow multdiv unit between two requesters
// Operands are held for the whole op; a killed op still drains because the unit cannot abort.
module ibex_multdiv_arbiter
  import ibex_multdiv_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input logic                   CK,
  input logic                   rst_ni,
  ibex_multdiv_arbiter_if.slave bus
);

  logic [1:0]  state_q, state_d;
  md_req_t     req_q, req_new;
  logic        owner_q;
  logic        last_grant_q;
  logic        killed_q;
  logic [31:0] result_q;

  logic [1:0]  req_valid, grant, kill, rsp_ready;
  logic        is_idle, is_busy, is_resp;
  logic        accept, kill_owner, rsp_ack;
  logic        rsp0_valid, rsp1_valid;

  assign req_valid = {bus.req1_valid_i, bus.req0_valid_i};
  assign kill      = {bus.kill1_i, bus.kill0_i};
  assign rsp_ready = {bus.rsp1_ready_i, bus.rsp0_ready_i};

  assign is_idle = (state_q == ARB_IDLE);
  assign is_busy = (state_q == ARB_BUSY);
  assign is_resp = (state_q == ARB_RESP);

  ibex_rr_arb2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_rr_arb2 (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign accept           = is_idle & (|grant);
  assign bus.req0_ready_o = is_idle & grant[0];
  assign bus.req1_ready_o = is_idle & grant[1];

  assign req_new = grant[1] ?
      {bus.req1_operator_i, bus.req1_signed_mode_i, bus.req1_op_a_i, bus.req1_op_b_i} :
      {bus.req0_operator_i, bus.req0_signed_mode_i, bus.req0_op_a_i, bus.req0_op_b_i};

  assign kill_owner = owner_q ? kill[1] : kill[0];
  assign rsp_ack    = owner_q ? rsp_ready[1] : rsp_ready[0];

  // Kill takes precedence over ready in RESP; both simply release the unit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (accept) state_d = ARB_BUSY;
      ARB_BUSY: if (bus.md_valid_i) state_d = (killed_q || kill_owner) ? ARB_IDLE : ARB_RESP;
      ARB_RESP: if (kill_owner || rsp_ack) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_IDLE;
      req_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      killed_q     <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q        <= req_new;
        owner_q      <= grant[1];
        last_grant_q <= grant[1];
        killed_q     <= 1'b0;
      end
      if (is_busy) begin
        if (bus.md_valid_i) begin
          result_q <= bus.md_result_i;
          killed_q <= 1'b0;
        end else if (kill_owner) begin
          killed_q <= 1'b1;
        end
      end
    end
  end

  assign bus.md_mult_en_o     = is_busy & ~req_q.operator[1];
  assign bus.md_div_en_o      = is_busy & req_q.operator[1];
  assign bus.md_operator_o    = {2{is_busy}} & req_q.operator;
  assign bus.md_signed_mode_o = {2{is_busy}} & req_q.signed_mode;
  assign bus.md_op_a_o        = {32{is_busy}} & req_q.op_a;
  assign bus.md_op_b_o        = {32{is_busy}} & req_q.op_b;

  assign rsp0_valid        = is_resp & ~owner_q;
  assign rsp1_valid        = is_resp & owner_q;
  assign bus.rsp0_valid_o  = rsp0_valid;
  assign bus.rsp1_valid_o  = rsp1_valid;
  assign bus.rsp0_result_o = {32{rsp0_valid}} & result_q;
  assign bus.rsp1_result_o = {32{rsp1_valid}} & result_q;

endmodule
